// File: rtl/rv_pkg.sv
// Shared RV32I encodings for the decode slice: opcodes, funct7 values,
// out_flags bit positions and the opcode-to-immediate-format mapping.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam int unsigned FLAGS_W    = 9;
   localparam int unsigned FL_ALU     = 0;
   localparam int unsigned FL_LOAD    = 1;
   localparam int unsigned FL_STORE   = 2;
   localparam int unsigned FL_BRANCH  = 3;
   localparam int unsigned FL_JAL     = 4;
   localparam int unsigned FL_JALR    = 5;
   localparam int unsigned FL_LUI     = 6;
   localparam int unsigned FL_AUIPC   = 7;
   localparam int unsigned FL_ILLEGAL = 8;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } fmt_e;

   // R-type and unknown opcodes both map to FMT_NONE (immediate of zero).
   function automatic fmt_e opcode_fmt(input logic [6:0] op);
      fmt_e f;
      case (op)
         OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
         OP_STORE:                 f = FMT_S;
         OP_BRANCH:                f = FMT_B;
         OP_LUI, OP_AUIPC:         f = FMT_U;
         OP_JAL:                   f = FMT_J;
         default:                  f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extractor, sign-extended (or truncated) to XLEN.
module imm_gen #(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);
   import rv_pkg::*;

   logic signed [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (opcode_fmt(instr[6:0]))
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Signed cast sign-extends when XLEN > 32.
   assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle, reads operands with
// write-back bypass, and holds the result in a valid/ready output register.
module decode_stage #(
   parameter int unsigned XLEN             = 32,
   parameter int unsigned REG_AW           = 5,
   parameter bit          BYPASS_EN        = 1'b1,
   parameter bit          STALL_REFRESH_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic [REG_AW-1:0] rf_ra1,
   output logic [REG_AW-1:0] rf_ra2,
   input  logic [XLEN-1:0]   rf_rd1,
   input  logic [XLEN-1:0]   rf_rd2,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [6:0]        out_opcode,
   output logic [REG_AW-1:0] out_rd,
   output logic [REG_AW-1:0] out_rs1_addr,
   output logic [REG_AW-1:0] out_rs2_addr,
   output logic [2:0]        out_funct3,
   output logic [6:0]        out_funct7,
   output logic [XLEN-1:0]   out_rs1_val,
   output logic [XLEN-1:0]   out_rs2_val,
   output logic [XLEN-1:0]   out_imm,
   output logic [8:0]        out_flags,
   output logic              out_alu_src_imm
);
   import rv_pkg::*;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic [REG_AW-1:0]  rd;
   logic [XLEN-1:0]    imm;
   logic [FLAGS_W-1:0] flags;
   logic               src_imm;
   logic               illegal;
   logic [XLEN-1:0]    rs1_val;
   logic [XLEN-1:0]    rs2_val;
   logic               accept;
   logic               refresh;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign rd     = REG_AW'(in_instr[11:7]);
   assign rf_ra1 = REG_AW'(in_instr[19:15]);
   assign rf_ra2 = REG_AW'(in_instr[24:20]);

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign refresh  = STALL_REFRESH_EN && out_valid && !out_ready && wb_we && (wb_addr != '0);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr),
      .imm   (imm)
   );

   always_comb begin
      flags   = '0;
      src_imm = 1'b0;
      illegal = (in_instr[1:0] != 2'b11);
      case (opcode)
         OP_R: begin
            if (funct7 == F7_ZERO || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
               flags[FL_ALU] = 1'b1;
            else
               illegal = 1'b1;
         end
         OP_IMM:    begin flags[FL_ALU]    = 1'b1; src_imm = 1'b1; end
         OP_LOAD:   begin flags[FL_LOAD]   = 1'b1; src_imm = 1'b1; end
         OP_STORE:  begin flags[FL_STORE]  = 1'b1; src_imm = 1'b1; end
         OP_BRANCH: flags[FL_BRANCH] = 1'b1;
         OP_JAL:    flags[FL_JAL]    = 1'b1;
         OP_JALR:   begin flags[FL_JALR]   = 1'b1; src_imm = 1'b1; end
         OP_LUI:    begin flags[FL_LUI]    = 1'b1; src_imm = 1'b1; end
         OP_AUIPC:  begin flags[FL_AUIPC]  = 1'b1; src_imm = 1'b1; end
         default:   illegal = 1'b1;
      endcase
      if (illegal) begin
         flags              = '0;
         src_imm            = 1'b0;
         flags[FL_ILLEGAL]  = 1'b1;
      end
   end

   always_comb begin
      rs1_val = rf_rd1;
      rs2_val = rf_rd2;
      if (rf_ra1 == '0)
         rs1_val = '0;
      else if (BYPASS_EN && wb_we && wb_addr == rf_ra1)
         rs1_val = wb_data;
      if (rf_ra2 == '0)
         rs2_val = '0;
      else if (BYPASS_EN && wb_we && wb_addr == rf_ra2)
         rs2_val = wb_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid       <= 1'b0;
         out_pc          <= '0;
         out_opcode      <= '0;
         out_rd          <= '0;
         out_rs1_addr    <= '0;
         out_rs2_addr    <= '0;
         out_funct3      <= '0;
         out_funct7      <= '0;
         out_rs1_val     <= '0;
         out_rs2_val     <= '0;
         out_imm         <= '0;
         out_flags       <= '0;
         out_alu_src_imm <= 1'b0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (accept)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;

         if (accept) begin
            out_pc          <= in_pc;
            out_opcode      <= opcode;
            out_rd          <= rd;
            out_rs1_addr    <= rf_ra1;
            out_rs2_addr    <= rf_ra2;
            out_funct3      <= funct3;
            out_funct7      <= funct7;
            out_rs1_val     <= rs1_val;
            out_rs2_val     <= rs2_val;
            out_imm         <= imm;
            out_flags       <= flags;
            out_alu_src_imm <= src_imm;
         end else if (refresh) begin
            // A held entry must not go stale while execute stalls it.
            if (wb_addr == out_rs1_addr)
               out_rs1_val <= wb_data;
            if (wb_addr == out_rs2_addr)
               out_rs2_val <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, all compared against a behavioural decode/pipeline model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic [4:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [6:0]  out_opcode;
   logic [4:0]  out_rd, out_rs1_addr, out_rs2_addr;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [31:0] out_rs1_val, out_rs2_val, out_imm;
   logic [8:0]  out_flags;
   logic        out_alu_src_imm;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .REG_AW(5), .BYPASS_EN(1'b1), .STALL_REFRESH_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1_addr(out_rs1_addr),
      .out_rs2_addr(out_rs2_addr), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
      .out_flags(out_flags), .out_alu_src_imm(out_alu_src_imm)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [6:0]  opc;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] v1, v2, imm;
      logic [8:0]  flags;
      logic        src;
   } ent_t;

   ent_t exp_e;

   function automatic ent_t zero_ent();
      ent_t e;
      e.valid = 0; e.pc = 0; e.opc = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
      e.f3 = 0; e.f7 = 0; e.v1 = 0; e.v2 = 0; e.imm = 0; e.flags = 0; e.src = 0;
      return e;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rd,
                                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0) return 0;
      if (we && wa == a) return wd;
      return rd;
   endfunction

   // Reference decode written from the ISA tables: immediates assembled by shifts.
   function automatic ent_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic we, input logic [4:0] wa, input logic [31:0] wd);
      ent_t e;
      logic [31:0] sx;
      logic alu, ld, st, br, jal, jalr, lui, auipc, ill;
      alu = 0; ld = 0; st = 0; br = 0; jal = 0; jalr = 0; lui = 0; auipc = 0; ill = 0;
      sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
      e.valid = 1; e.pc = pc; e.opc = ins[6:0]; e.rd = ins[11:7]; e.f3 = ins[14:12];
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f7 = ins[31:25];
      e.v1 = operand(e.rs1, rd1, we, wa, wd);
      e.v2 = operand(e.rs2, rd2, we, wa, wd);
      e.imm = 0; e.src = 0;
      case (ins[6:0])
         7'h33: begin
            if (e.f7 == 7'h00 || (e.f7 == 7'h20 && (e.f3 == 0 || e.f3 == 5))) alu = 1;
            else ill = 1;
         end
         7'h13: begin alu = 1; e.src = 1; e.imm = (sx << 11) | 32'(ins[30:20]); end
         7'h03: begin ld = 1;  e.src = 1; e.imm = (sx << 11) | 32'(ins[30:20]); end
         7'h67: begin jalr = 1; e.src = 1; e.imm = (sx << 11) | 32'(ins[30:20]); end
         7'h23: begin st = 1; e.src = 1;
            e.imm = (sx << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]); end
         7'h63: begin br = 1;
            e.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
         7'h6F: begin jal = 1;
            e.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1); end
         7'h37: begin lui = 1;   e.src = 1; e.imm = ins & 32'hFFFF_F000; end
         7'h17: begin auipc = 1; e.src = 1; e.imm = ins & 32'hFFFF_F000; end
         default: ill = 1;
      endcase
      if (ill) e.flags = 9'h100;
      else e.flags = {1'b0, auipc, lui, jalr, jal, br, st, ld, alu};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(exp_e.valid));
      chk({tag, ".pc"},    out_pc, exp_e.pc);
      chk({tag, ".opc"},   32'(out_opcode), 32'(exp_e.opc));
      chk({tag, ".rd"},    32'(out_rd), 32'(exp_e.rd));
      chk({tag, ".rs1a"},  32'(out_rs1_addr), 32'(exp_e.rs1));
      chk({tag, ".rs2a"},  32'(out_rs2_addr), 32'(exp_e.rs2));
      chk({tag, ".f3"},    32'(out_funct3), 32'(exp_e.f3));
      chk({tag, ".f7"},    32'(out_funct7), 32'(exp_e.f7));
      chk({tag, ".v1"},    out_rs1_val, exp_e.v1);
      chk({tag, ".v2"},    out_rs2_val, exp_e.v2);
      chk({tag, ".imm"},   out_imm, exp_e.imm);
      chk({tag, ".flags"}, 32'(out_flags), 32'(exp_e.flags));
      chk({tag, ".src"},   32'(out_alu_src_imm), 32'(exp_e.src));
   endtask

   // One clock: drive inputs, check combinational outputs, advance model, check registers.
   task automatic step(input string tag, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] rd1, input logic [31:0] rd2);
      ent_t nxt;
      logic acc;
      in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
      wb_we = we; wb_addr = wa; wb_data = wd; rf_rd1 = rd1; rf_rd2 = rd2;
      #1;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(!exp_e.valid || ordy));
      chk({tag, ".ra1"}, 32'(rf_ra1), 32'(ins[19:15]));
      chk({tag, ".ra2"}, 32'(rf_ra2), 32'(ins[24:20]));
      nxt = exp_e;
      acc = iv && (!exp_e.valid || ordy) && !fl;
      if (acc) nxt = decode(ins, pc, rd1, rd2, we, wa, wd);
      else if (exp_e.valid && !ordy && we && wa != 0) begin
         if (wa == exp_e.rs1) nxt.v1 = wd;
         if (wa == exp_e.rs2) nxt.v2 = wd;
      end
      if (fl) nxt.valid = 0;
      else if (acc) nxt.valid = 1;
      else if (ordy) nxt.valid = 0;
      exp_e = nxt;
      @(posedge clk);
      #1;
      chk_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 0;
      exp_e = zero_ent();
      chk_outputs(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      int unsigned k;
      r = $urandom;
      k = $urandom_range(0, 10);
      if (k < 9) r[6:0] = ops[k];
      else if (r[6:0] == 7'h0F || r[6:0] == 7'h73) r[6:0] = 7'h7F;
      if (k == 0) begin
         case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
         endcase
      end
      return r;
   endfunction

   initial begin
      logic [31:0] held_pc;
      logic [31:0] ins;
      logic [4:0]  wa;
      reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0; rf_rd1 = 0; rf_rd2 = 0;
      exp_e = zero_ent();

      do_reset("reset");

      step("addi", 1, 32'h0050_0093, 32'h100, 0, 1, 0, 0, 0, 32'h77, 32'h88);
      chk("addi.lit_imm", out_imm, 32'd5);
      chk("addi.lit_rd", 32'(out_rd), 32'd1);
      chk("addi.lit_flags", 32'(out_flags), 32'h001);

      step("beq", 1, 32'hFE00_0EE3, 32'h104, 0, 1, 0, 0, 0, 32'h1, 32'h2);
      chk("beq.lit_imm", out_imm, 32'hFFFF_FFFC);
      step("sw", 1, 32'h0020_A423, 32'h108, 0, 1, 0, 0, 0, 32'h10, 32'h20);
      chk("sw.lit_imm", out_imm, 32'd8);

      step("add_byp", 1, 32'h0020_81B3, 32'h10C, 0, 1, 1, 5'd1, 32'hDEAD_BEEF, 32'h11, 32'h22);
      chk("add_byp.lit_v1", out_rs1_val, 32'hDEAD_BEEF);
      step("stall1", 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      step("stall2", 0, 32'h0, 32'h0, 0, 0, 1, 5'd2, 32'h1234, 0, 0);
      chk("stall2.lit_v2", out_rs2_val, 32'h1234);
      step("stall3", 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      step("release", 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 0, 0);

      step("ill_ones", 1, 32'hFFFF_FFFF, 32'h200, 0, 1, 0, 0, 0, 1, 2);
      chk("ill_ones.lit_flags", 32'(out_flags), 32'h100);
      step("ill_f7", 1, 32'h4000_1033, 32'h204, 0, 1, 0, 0, 0, 3, 4);
      chk("ill_f7.lit_flags", 32'(out_flags), 32'h100);

      step("pre_fl", 1, 32'h0050_0093, 32'h300, 0, 1, 0, 0, 0, 0, 0);
      held_pc = 32'h300;
      step("fl_stall", 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      step("flush", 1, 32'h0020_A423, 32'h304, 1, 0, 0, 0, 0, 5, 6);
      chk("flush.lit_pc", out_pc, held_pc);

      step("pre_rst", 1, 32'h0020_81B3, 32'h400, 0, 1, 0, 0, 0, 9, 9);
      step("rst_stall", 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      do_reset("mid_reset");

      for (int i = 0; i < 400; i++) begin
         ins = rand_instr();
         wa = 5'($urandom);
         if ($urandom_range(0, 2) == 0) wa = ins[19:15];
         else if ($urandom_range(0, 3) == 0 && exp_e.valid) wa = exp_e.rs2;
         step("rand", ($urandom_range(0, 3) != 0), ins, $urandom, ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1), wa, $urandom,
              $urandom, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
